pipelined_control_unit: RTL

- Registered, parametrised successor to the combinational RV32 main decoder.
- Decodes opcode/funct7 into the 8-bit control bundle and holds it in an output register with valid/ready handshakes on both sides.
- Supports flush and illegal-instruction flagging, plus optional multi-cycle sequencing of M-extension ops.
- Sits between IF/ID and the ID/EX boundary.

---
 rtl/pipelined_control_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipelined_control_unit.sv
// Registered RV32 main decoder with valid/ready on both sides, flush and illegal flagging.
// Optional multi-cycle M-extension sequencing is built when CTL_MULDIV_EN is defined.
module pipelined_control_unit #(
    parameter int CTL_W         = 8,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [6:0]       funct7,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CTL_W-1:0] ctl_out,
    output logic             illegal,
    output logic             muldiv,
    output logic             busy
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    generate
        if (CTL_W < 8 || MULDIV_CYCLES < 1) begin : g_bad_params
            $error("pipelined_control_unit: CTL_W must be >= 8 and MULDIV_CYCLES >= 1");
        end
    endgenerate

    logic [7:0] dec_ctl;
    logic       dec_ill;
    logic       dec_m;

    always_comb begin
        dec_ctl = 8'h00;
        dec_ill = 1'b0;
        dec_m   = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct7)
                    7'b0000000, 7'b0100000: dec_ctl = 8'h22;
`ifdef CTL_MULDIV_EN
                    7'b0000001: begin
                        dec_ctl = 8'h22;
                        dec_m   = 1'b1;
                    end
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_IMM:    dec_ctl = 8'hA3;
            OP_LOAD:   dec_ctl = 8'hF0;
            OP_STORE:  dec_ctl = 8'h88;
            OP_BRANCH: dec_ctl = 8'h04;
            OP_JAL:    dec_ctl = 8'h24;
            OP_JALR:   dec_ctl = 8'hA7;
            default:   dec_ill = 1'b1;
        endcase
    end

    logic             out_valid_q, out_valid_d;
    logic [CTL_W-1:0] ctl_q, ctl_d;
    logic             illegal_q, illegal_d;
    logic             idle;
    logic             slot_free;
    logic             accept;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = idle && slot_free && !flush;
    assign accept    = in_valid && in_ready;

`ifdef CTL_MULDIV_EN
    typedef enum logic {S_IDLE, S_MULDIV} state_t;

    localparam int              CNT_W    = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cap_q, cap_d;
    logic             muldiv_q, muldiv_d;

    assign idle   = (state_q == S_IDLE);
    assign busy   = (state_q == S_MULDIV);
    assign muldiv = muldiv_q;
`else
    assign idle   = 1'b1;
    assign busy   = 1'b0;
    assign muldiv = 1'b0;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        ctl_d       = ctl_q;
        illegal_d   = illegal_q;
`ifdef CTL_MULDIV_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        muldiv_d    = muldiv_q;
`endif
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        if (flush) begin
            out_valid_d = 1'b0;
`ifdef CTL_MULDIV_EN
            state_d = S_IDLE;
            cnt_d   = '0;
            cap_d   = 8'h00;
`endif
        end else begin
            // A new load replaces a draining entry in the same cycle: no bubble.
            if (accept && !dec_m) begin
                out_valid_d = 1'b1;
                ctl_d       = CTL_W'(dec_ctl);
                illegal_d   = dec_ill;
`ifdef CTL_MULDIV_EN
                muldiv_d    = 1'b0;
`endif
            end
`ifdef CTL_MULDIV_EN
            if (accept && dec_m) begin
                state_d = S_MULDIV;
                cnt_d   = CNT_LOAD;
                cap_d   = dec_ctl;
            end
            // Counter parks at zero until the output slot frees up.
            if (state_q == S_MULDIV) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (slot_free) begin
                    out_valid_d = 1'b1;
                    ctl_d       = CTL_W'(cap_q);
                    illegal_d   = 1'b0;
                    muldiv_d    = 1'b1;
                    state_d     = S_IDLE;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            ctl_q       <= '0;
            illegal_q   <= 1'b0;
`ifdef CTL_MULDIV_EN
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cap_q       <= 8'h00;
            muldiv_q    <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            ctl_q       <= ctl_d;
            illegal_q   <= illegal_d;
`ifdef CTL_MULDIV_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            muldiv_q    <= muldiv_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign ctl_out   = ctl_q;
    assign illegal   = illegal_q;

endmodule
